// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush sequencer for the 5-stage pipeline.
// Optional stall counter enabled by defining PIPE_STALL_COUNT_EN.
module pipeline_ctrl #(
    parameter int unsigned WAIT_MAX = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stop,
    input  logic        branch_taken,
    input  logic        dmem_req,
    input  logic        dmem_ready,
    input  logic        halt,
    output logic        pc_we,
    output logic        ifid_we,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        exmem_flush,
    output logic        pipe_we,
    output logic        halted,
    output logic        mem_err
`ifdef PIPE_STALL_COUNT_EN
    ,
    output logic [15:0] stall_count
`endif
);

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_WAIT   = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [7:0] r_cnt;
    logic [7:0] w_cnt_nxt;
    logic       r_err;
    logic       w_err_set;
    logic       w_run;
    logic       w_active;

    // Code 2'd3 is never entered; it falls into the halted decode.
    assign w_active = (r_state == S_RUN) || (r_state == S_WAIT);
    assign mem_err  = r_err;

    // Next-state and Mealy outputs; reset forces every output quiet.
    always_comb begin
        pc_we       = 1'b0;
        ifid_we     = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        pipe_we     = 1'b0;
        halted      = 1'b0;
        w_next      = r_state;
        w_cnt_nxt   = r_cnt;
        w_err_set   = 1'b0;
        w_run       = 1'b0;

        case (r_state)
            S_RUN: w_run = 1'b1;
            S_WAIT: begin
                if (dmem_ready) begin
                    w_run = 1'b1;
                end else if (r_cnt == 8'(WAIT_MAX)) begin
                    w_next    = S_HALTED;
                    w_err_set = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            default: halted = 1'b1;
        endcase

        // Frozen branch/stop from a wait are honoured on the exit cycle.
        if (w_run) begin
            w_next    = S_RUN;
            w_cnt_nxt = 8'd0;
            if (halt) begin
                w_next = S_HALTED;
            end else if (dmem_req && !dmem_ready) begin
                w_next    = S_WAIT;
                w_cnt_nxt = 8'd1;
            end else if (branch_taken) begin
                pc_we       = 1'b1;
                ifid_we     = 1'b1;
                pipe_we     = 1'b1;
                ifid_flush  = 1'b1;
                idex_flush  = 1'b1;
                exmem_flush = 1'b1;
            end else if (stop) begin
                idex_flush = 1'b1;
                pipe_we    = 1'b1;
            end else begin
                pc_we   = 1'b1;
                ifid_we = 1'b1;
                pipe_we = 1'b1;
            end
        end

        if (reset) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            ifid_flush  = 1'b0;
            idex_flush  = 1'b0;
            exmem_flush = 1'b0;
            pipe_we     = 1'b0;
            halted      = 1'b0;
        end
    end

    // State, wait counter and sticky timeout flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_RUN;
            r_cnt   <= 8'd0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_nxt;
            r_err   <= r_err | w_err_set;
        end
    end

`ifdef PIPE_STALL_COUNT_EN
    logic [15:0] r_stall;

    assign stall_count = r_stall;

    // Saturating count of cycles in which the PC is held.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall <= 16'd0;
        end else if (w_active && !pc_we && (r_stall != 16'hFFFF)) begin
            r_stall <= r_stall + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: vector table, corner sequences and random
// stimulus against a rule-level model of the sequencer.
module tb_pipeline_ctrl;

    localparam int WM = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic stop = 1'b0;
    logic branch_taken = 1'b0;
    logic dmem_req = 1'b0;
    logic dmem_ready = 1'b0;
    logic halt = 1'b0;
    logic pc_we, ifid_we, ifid_flush, idex_flush;
    logic exmem_flush, pipe_we, halted, mem_err;
`ifdef PIPE_STALL_COUNT_EN
    logic [15:0] stall_count;
`endif

    pipeline_ctrl #(.WAIT_MAX(WM)) dut (
        .clk(clk),
        .reset(reset),
        .stop(stop),
        .branch_taken(branch_taken),
        .dmem_req(dmem_req),
        .dmem_ready(dmem_ready),
        .halt(halt),
        .pc_we(pc_we),
        .ifid_we(ifid_we),
        .ifid_flush(ifid_flush),
        .idex_flush(idex_flush),
        .exmem_flush(exmem_flush),
        .pipe_we(pipe_we),
        .halted(halted),
        .mem_err(mem_err)
`ifdef PIPE_STALL_COUNT_EN
        ,
        .stall_count(stall_count)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: is the core halted, stuck waiting (and for how long), etc.
    bit m_halt = 0;
    bit m_wait = 0;
    bit m_err = 0;
    int m_waits = 0;
    int m_stall = 0;

    typedef struct {
        logic s, b, q, r, h;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl[12];

    function automatic logic [7:0] outs();
        return {pc_we, ifid_we, ifid_flush, idex_flush,
                exmem_flush, pipe_we, halted, mem_err};
    endfunction

    // {pc_we,ifid_we,ifid_fl,idex_fl,exmem_fl,pipe_we,halted,mem_err}
    function automatic logic [7:0] model_out(logic s, logic b, logic q,
                                             logic r, logic h);
        logic [7:0] o;
        if (m_halt)            o = 8'h02;
        else if (m_wait && !r) o = 8'h00;
        else if (h)            o = 8'h00;
        else if (q && !r)      o = 8'h00;
        else if (b)            o = 8'hFC;
        else if (s)            o = 8'h14;
        else                   o = 8'hC4;
        o[0] = m_err;
        return o;
    endfunction

    task automatic model_step(logic q, logic r, logic h, logic pcwe);
        if (!m_halt && !pcwe && m_stall < 65535) m_stall++;
        if (m_halt) begin
        end else if (m_wait && !r) begin
            if (m_waits == WM) begin
                m_halt = 1;
                m_err  = 1;
                m_wait = 0;
            end else begin
                m_waits++;
            end
        end else begin
            m_wait = 0;
            if (h) begin
                m_halt = 1;
            end else if (q && !r) begin
                m_wait  = 1;
                m_waits = 1;
            end
        end
    endtask

    task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Called at posedge+1: drive, check at +3, advance one clock.
    task automatic cyc(logic s, logic b, logic q, logic r, logic h,
                       logic [7:0] exp, string nm);
        logic [7:0] m;
        m = model_out(s, b, q, r, h);
        stop = s;
        branch_taken = b;
        dmem_req = q;
        dmem_ready = r;
        halt = h;
        #2;
        chk(nm, {8'h00, outs()}, {8'h00, exp});
`ifdef PIPE_STALL_COUNT_EN
        chk({nm, "_stall"}, stall_count, 16'(m_stall));
`endif
        model_step(q, r, h, m[7]);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        stop = 1;
        branch_taken = 1;
        dmem_req = 1;
        dmem_ready = 1;
        halt = 0;
        reset = 1;
        #2;
        chk("reset_outs", {8'h00, outs()}, 16'h0000);
        @(posedge clk);
        #1;
        reset = 0;
        m_halt = 0;
        m_wait = 0;
        m_err = 0;
        m_waits = 0;
        m_stall = 0;
    endtask

    initial begin
        tbl[0]  = '{0, 0, 0, 0, 0, 8'hC4};
        tbl[1]  = '{1, 0, 0, 0, 0, 8'h14};
        tbl[2]  = '{0, 0, 0, 0, 0, 8'hC4};
        tbl[3]  = '{1, 1, 0, 0, 0, 8'hFC};
        tbl[4]  = '{0, 0, 1, 1, 0, 8'hC4};
        tbl[5]  = '{1, 1, 1, 0, 0, 8'h00};
        tbl[6]  = '{1, 1, 1, 0, 0, 8'h00};
        tbl[7]  = '{1, 1, 1, 1, 0, 8'hFC};
        tbl[8]  = '{1, 0, 0, 0, 0, 8'h14};
        tbl[9]  = '{0, 1, 0, 0, 1, 8'h00};
        tbl[10] = '{0, 0, 0, 0, 0, 8'h02};
        tbl[11] = '{1, 0, 1, 0, 0, 8'h02};

        @(posedge clk);
        #1;
        do_reset();

        for (int i = 0; i < 12; i++) begin
            cyc(tbl[i].s, tbl[i].b, tbl[i].q, tbl[i].r, tbl[i].h,
                tbl[i].exp, $sformatf("tbl%0d", i));
        end

        // Three-cycle memory wait then advance.
        do_reset();
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 0, 8'h00, "w3_frz");
        cyc(0, 0, 1, 1, 0, 8'hC4, "w3_go");
`ifdef PIPE_STALL_COUNT_EN
        chk("w3_count", stall_count, 16'd3);
`endif
        cyc(0, 0, 0, 0, 0, 8'hC4, "w3_after");

        // Timeout: request cycle, WM wait cycles, then halted + error.
        do_reset();
        cyc(0, 0, 1, 0, 0, 8'h00, "to_req");
        for (int i = 0; i < WM; i++) cyc(0, 0, 1, 0, 0, 8'h00, "to_wait");
        for (int i = 0; i < 3; i++) cyc(1, 1, 1, 1, 0, 8'h03, "to_halt");

        // Reset mid-wait clears the error and returns to RUN at once.
        do_reset();
        cyc(0, 0, 1, 0, 0, 8'h00, "mw_req");
        cyc(1, 0, 1, 0, 0, 8'h00, "mw_wait");
        do_reset();
        cyc(0, 0, 0, 0, 0, 8'hC4, "mw_run");

        // Random traffic checked against the model.
        for (int i = 0; i < 3000; i++) begin
            logic s, b, q, r, h;
            if ($urandom_range(0, 59) == 0) begin
                do_reset();
            end else begin
                s = 1'($urandom_range(0, 1));
                b = ($urandom_range(0, 3) == 0);
                q = 1'($urandom_range(0, 1));
                r = 1'($urandom_range(0, 1));
                h = ($urandom_range(0, 99) == 0);
                cyc(s, b, q, r, h, model_out(s, b, q, r, h), "rand");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
